ps2_cmd_ctrl: RTL

//  Sequencer between the PS/2 keyboard receiver and the LifeGame core. Consumes
//  one scancode byte per strobe, resolves E0/F0 prefixes, and keeps cursor

---
 rtl/ps2_cmd_ctrl_if.sv | 33 +++
 rtl/ps2_cmd_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_ctrl_if.sv
// ps2_cmd_ctrl_if: scancode input strobe and command handshake between the
// PS/2 receiver, the command sequencer and the LifeGame core.
//
// Handshake: code_vld is a one-cycle strobe qualifying code. On the command
// side cmd_vld/cmd are driven from registers and cmd is stable while cmd_vld
// is high; a command transfers on every rising clock edge that samples
// cmd_vld & cmd_rdy both high. cmd_rdy never feeds cmd_vld combinationally.
`timescale 1ns/1ps
interface ps2_cmd_ctrl_if;
  logic       code_vld;
  logic [7:0] code;
  logic       cmd_vld;
  logic [1:0] cmd;
  logic       cmd_rdy;

  // Sequencer side: consumes scancodes, offers commands.
  modport slave (
    input  code_vld,
    input  code,
    input  cmd_rdy,
    output cmd_vld,
    output cmd
  );

  // Environment side: supplies scancodes, accepts commands.
  modport master (
    output code_vld,
    output code,
    output cmd_rdy,
    input  cmd_vld,
    input  cmd
  );
endinterface

// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: turns a PS/2 scancode stream into cursor moves, run toggles
// and single TOGGLE/CLEAR/STEP commands for the LifeGame core.
// Optional build macro: KEY_REPEAT_FILTER_EN (per-key held flags so that
// typematic repeats of SPACE/R/S/ENTER act once per press).
// dbg_state exposes the prefix decoder state (0 IDLE, 1 EXT, 2 BRK, 3 EXT_BRK).
`timescale 1ns/1ps
module ps2_cmd_ctrl #(
  parameter int GRID_W      = 64,
  parameter int GRID_H      = 48,
  parameter int XW          = 6,
  parameter int YW          = 6,
  parameter int PFX_TIMEOUT = 250000
) (
  input  logic          clk_25mhz,
  input  logic          clr,
  ps2_cmd_ctrl_if.slave bus,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          run,
  output logic          ovf,
  output logic [1:0]    dbg_state
);

  localparam int CW = (PFX_TIMEOUT > 2) ? $clog2(PFX_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PFX_TIMEOUT - 1);

  localparam logic [7:0] C_BRK   = 8'hF0;
  localparam logic [7:0] C_EXT   = 8'hE0;
  localparam logic [7:0] K_SPACE = 8'h29;
  localparam logic [7:0] K_R     = 8'h2D;
  localparam logic [7:0] K_S     = 8'h1B;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [7:0] K_LEFT  = 8'h6B;
  localparam logic [7:0] K_RIGHT = 8'h74;

  localparam logic [1:0] CMD_TOGGLE = 2'd0;
  localparam logic [1:0] CMD_CLEAR  = 2'd1;
  localparam logic [1:0] CMD_STEP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          run_q, run_d;
  logic          ovf_q, ovf_d;
  logic          cmd_vld_q, cmd_vld_d;
  logic [1:0]    cmd_q, cmd_d;

  // Decoded final byte of a frame.
  logic       is_make;
  logic       is_brk;
  logic       is_ext;
  // One-hot std key hit {ENTER, S, R, SPACE} and the subset that acts.
  logic [3:0] key_hit;
  logic [3:0] key_act;
  logic       new_vld;
  logic [1:0] new_cmd;

`ifdef KEY_REPEAT_FILTER_EN
  logic [3:0] held_q, held_d;
`endif

  // Prefix decoder next state and timeout counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.code_vld) begin
          if (bus.code == C_BRK)      state_d = ST_BRK;
          else if (bus.code == C_EXT) state_d = ST_EXT;
          else                        is_make = 1'b1;
        end
      end
      ST_EXT: begin
        if (bus.code_vld) begin
          if (bus.code == C_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BRK, ST_EXT_BRK: begin
        if (bus.code_vld) begin
          is_brk  = 1'b1;
          is_ext  = (state_q == ST_EXT_BRK);
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Key map, repeat filter, cursor/run update and command slot next state.
  always_comb begin
    key_hit   = 4'b0000;
    key_act   = 4'b0000;
    new_vld   = 1'b0;
    new_cmd   = CMD_TOGGLE;
    x_d       = x_q;
    y_d       = y_q;
    run_d     = run_q;
    ovf_d     = ovf_q;
    cmd_vld_d = cmd_vld_q;
    cmd_d     = cmd_q;
`ifdef KEY_REPEAT_FILTER_EN
    held_d    = held_q;
`endif

    case (bus.code)
      K_SPACE: key_hit = 4'b0001;
      K_R:     key_hit = 4'b0010;
      K_S:     key_hit = 4'b0100;
      K_ENTER: key_hit = 4'b1000;
      default: key_hit = 4'b0000;
    endcase

`ifdef KEY_REPEAT_FILTER_EN
    // A make only acts on the first press; the break re-arms the key.
    if (is_make && !is_ext) begin
      key_act = key_hit & ~held_q;
      held_d  = held_q | key_hit;
    end
    if (is_brk && !is_ext) held_d = held_q & ~key_hit;
`else
    if (is_make && !is_ext) key_act = key_hit;
`endif

    if (key_act[0]) begin
      new_vld = 1'b1;
      new_cmd = CMD_TOGGLE;
    end
    if (key_act[1]) begin
      new_vld = 1'b1;
      new_cmd = CMD_CLEAR;
    end
    // STEP is meaningless while free-running, so it is dropped without ovf.
    if (key_act[2] && !run_q) begin
      new_vld = 1'b1;
      new_cmd = CMD_STEP;
    end
    if (key_act[3]) run_d = ~run_q;

    // Arrows move one cell on every make, wrapping at the grid edges.
    if (is_make && is_ext) begin
      case (bus.code)
        K_UP:    y_d = (y_q == '0) ? YW'(GRID_H - 1) : y_q - 1'b1;
        K_DOWN:  y_d = (y_q == YW'(GRID_H - 1)) ? '0 : y_q + 1'b1;
        K_LEFT:  x_d = (x_q == '0) ? XW'(GRID_W - 1) : x_q - 1'b1;
        K_RIGHT: x_d = (x_q == XW'(GRID_W - 1)) ? '0 : x_q + 1'b1;
        default: ;
      endcase
    end

    // Single pending slot; a retiring slot may take the new command the same edge.
    if (new_vld) begin
      if (!cmd_vld_q || bus.cmd_rdy) begin
        cmd_vld_d = 1'b1;
        cmd_d     = new_cmd;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (cmd_vld_q && bus.cmd_rdy) begin
      cmd_vld_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk_25mhz or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      run_q     <= 1'b0;
      ovf_q     <= 1'b0;
      cmd_vld_q <= 1'b0;
      cmd_q     <= CMD_TOGGLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      run_q     <= run_d;
      ovf_q     <= ovf_d;
      cmd_vld_q <= cmd_vld_d;
      cmd_q     <= cmd_d;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  // Held flags for SPACE/R/S/ENTER.
  always_ff @(posedge clk_25mhz or negedge clr) begin
    if (!clr) held_q <= 4'b0000;
    else      held_q <= held_d;
  end
`endif

  assign bus.cmd_vld = cmd_vld_q;
  assign bus.cmd     = cmd_q;
  assign cursor_x    = x_q;
  assign cursor_y    = y_q;
  assign run         = run_q;
  assign ovf         = ovf_q;
  assign dbg_state   = state_q;

endmodule
